// File: rtl/sram_arbiter.sv
// Arbiter for one asynchronous SRAM shared by a video read port and a CPU read/write port.
// Video has priority. After MAX_VID_RUN video grants while the CPU waits, the CPU is granted.
//
// state  | meaning
// IDLE   | sample requests, grant one and latch its command
// VID_RD | video read strobes active for ACCESS_CYCLES cycles
// CPU_RD | CPU read strobes active for ACCESS_CYCLES cycles
// CPU_WR | CPU write, DQ driven, WE_N released in the final cycle
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_VID_RUN   = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVID_REQ,
    input  logic [17:0] iVID_ADDR,
    output logic        oVID_ACK,
    output logic [15:0] oVID_DATA,
    input  logic        iCPU_REQ,
    input  logic        iCPU_WE,
    input  logic [17:0] iCPU_ADDR,
    input  logic [15:0] iCPU_WDATA,
    input  logic [1:0]  iCPU_BE_N,
    output logic        oCPU_ACK,
    output logic [15:0] oCPU_RDATA,
    output logic [17:0] oSRAM_ADDR,
    inout  wire  [15:0] ioSRAM_DQ,
    output logic        oSRAM_CE_N,
    output logic        oSRAM_OE_N,
    output logic        oSRAM_WE_N,
    output logic        oSRAM_UB_N,
    output logic        oSRAM_LB_N,
    output logic        oBUSY
);

    localparam int RUN_W = $clog2(MAX_VID_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);
    localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, VID_RD, CPU_RD, CPU_WR} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;
    logic [15:0]      vid_data_q, vid_data_d, cpu_rdata_q, cpu_rdata_d;
    logic [17:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [1:0]       be_n_q, be_n_d;
    logic             ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic             ub_n_q, ub_n_d, lb_n_q, lb_n_d, dq_oe_q, dq_oe_d;
    logic             cpu_win, vid_win, grant_vid, grant_cpu, last_cycle;

    // A requester that is being acked this cycle still shows its old request, so it is not re-granted.
    always_comb begin
        cpu_win    = iCPU_REQ && (!iVID_REQ || run_q == RUN_MAX);
        vid_win    = iVID_REQ && !cpu_win;
        grant_vid  = (state_q == IDLE) && vid_win && !vid_ack_q;
        grant_cpu  = (state_q == IDLE) && cpu_win && !cpu_ack_q;
        last_cycle = (state_q != IDLE) && (cnt_q == LAST_CNT);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_n_d      = be_n_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;
        run_d       = run_q;

        case (state_q)
            IDLE: begin
                if (grant_vid) begin
                    state_d = VID_RD;
                    cnt_d   = 3'd0;
                    addr_d  = iVID_ADDR;
                    be_n_d  = 2'b00;
                end else if (grant_cpu) begin
                    state_d = iCPU_WE ? CPU_WR : CPU_RD;
                    cnt_d   = 3'd0;
                    addr_d  = iCPU_ADDR;
                    wdata_d = iCPU_WDATA;
                    be_n_d  = iCPU_BE_N;
                end
            end
            default: begin
                if (last_cycle) begin
                    state_d   = IDLE;
                    vid_ack_d = (state_q == VID_RD);
                    cpu_ack_d = (state_q != VID_RD);
                    if (state_q == VID_RD) vid_data_d = ioSRAM_DQ;
                    if (state_q == CPU_RD) cpu_rdata_d = ioSRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        endcase

        if (!iCPU_REQ || grant_cpu)
            run_d = '0;
        else if (grant_vid && run_q != RUN_MAX)
            run_d = run_q + 1'b1;

        // Strobes are decoded from the next state so the registered pins line up with the access cycles.
        ce_n_d  = (state_d == IDLE);
        oe_n_d  = !(state_d == VID_RD || state_d == CPU_RD);
        we_n_d  = !(state_d == CPU_WR && cnt_d != LAST_CNT);
        ub_n_d  = ce_n_d | be_n_d[1];
        lb_n_d  = ce_n_d | be_n_d[0];
        dq_oe_d = (state_d == CPU_WR);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            run_q       <= '0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= 2'b11;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_n_q      <= be_n_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign ioSRAM_DQ  = dq_oe_q ? wdata_q : 16'hzzzz;
    assign oSRAM_ADDR = addr_q;
    assign oSRAM_CE_N = ce_n_q;
    assign oSRAM_OE_N = oe_n_q;
    assign oSRAM_WE_N = we_n_q;
    assign oSRAM_UB_N = ub_n_q;
    assign oSRAM_LB_N = lb_n_q;
    assign oVID_ACK   = vid_ack_q;
    assign oVID_DATA  = vid_data_q;
    assign oCPU_ACK   = cpu_ack_q;
    assign oCPU_RDATA = cpu_rdata_q;
    assign oBUSY      = (state_q != IDLE);

endmodule
